// File: rtl/nrf24_controller_rx.sv
// nrf24_controller_rx: receive-only nRF24L01 controller.
// Runs the radio init sequence over a byte-wide SPI master, then services
// IRQ_n by reading STATUS, fetching one-byte payloads from pipe 0 and
// clearing the interrupt flags.
// Optional feature: define NRF24_RX_WATCHDOG_EN to build the link watchdog
// that raises link_lost when no payload arrives within WDOG_MS.
module nrf24_controller_rx #(
  parameter int unsigned SYS_CLK_HZ  = 100_000_000,
  parameter logic [7:0]  RF_CHANNEL  = 8'h4c,
  parameter logic [39:0] NRF_RX_ADDR = 40'hE7E7E7E7E7,
  parameter int unsigned WDOG_MS     = 100
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic        spi_hold_csn,
  output logic        CE,
  input  logic        IRQ_n,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        link_ready,
  output logic [15:0] pkt_cnt,
  output logic        rx_err,
  output logic        link_lost
);

  // Power-up settle time: 2 ms expressed in system clocks, minus one for the
  // zero-based counter.
  localparam logic [31:0] WAIT_LAST = 32'(2 * (SYS_CLK_HZ / 1000) - 1);

  typedef enum logic [3:0] {
    ST_CFG   = 4'd0,  // CONFIG write
    ST_WAIT  = 4'd1,  // settle delay after power-up
    ST_INIT  = 4'd2,  // remaining init transactions, indexed by tidx_q
    ST_IDLE  = 4'd3,  // waiting for IRQ
    ST_NOP   = 4'd4,  // read STATUS via NOP
    ST_READ  = 4'd5,  // R_RX_PAYLOAD + one dummy byte
    ST_FLUSH = 4'd6,  // FLUSH_RX after an invalid pipe
    ST_CLR   = 4'd7   // STATUS write with clr_val_q
  } state_t;

  state_t      state_q;
  logic        busy_q;       // a byte is in flight in the SPI master
  logic [2:0]  bidx_q;       // index of the byte in flight
  logic [3:0]  tidx_q;       // init transaction index
  logic [31:0] wait_q;
  logic [7:0]  clr_val_q;    // flags to clear in the closing STATUS write
  logic [2:0]  irq_sync_q;

  logic        spi_start_q;
  logic [7:0]  spi_tx_q;
  logic        spi_hold_csn_q;
  logic        ce_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        link_ready_q;
  logic [15:0] pkt_cnt_q;
  logic        rx_err_q;

  logic [2:0]  nxt_idx_s;
  logic [7:0]  tx_byte_s;
  logic [2:0]  cur_last_s;

  // Select reg/command byte for index 0, data byte otherwise.
  function automatic logic [7:0] pick(input logic [2:0] b, input logic [7:0] cmd_b,
                                      input logic [7:0] dat_b);
    return (b == 3'd0) ? cmd_b : dat_b;
  endfunction

  // Receive address is sent least-significant byte first.
  function automatic logic [7:0] addr_byte(input logic [2:0] b);
    logic [7:0] v;
    v = 8'hFF;
    case (b)
      3'd1:    v = NRF_RX_ADDR[7:0];
      3'd2:    v = NRF_RX_ADDR[15:8];
      3'd3:    v = NRF_RX_ADDR[23:16];
      3'd4:    v = NRF_RX_ADDR[31:24];
      3'd5:    v = NRF_RX_ADDR[39:32];
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  // Byte b of init transaction t (the ones following the settle delay).
  function automatic logic [7:0] init_byte(input logic [3:0] t, input logic [2:0] b);
    logic [7:0] v;
    v = 8'hFF;
    case (t)
      4'd0:    v = pick(b, 8'h21, 8'h01);        // EN_AA
      4'd1:    v = pick(b, 8'h22, 8'h01);        // EN_RXADDR
      4'd2:    v = pick(b, 8'h23, 8'h03);        // SETUP_AW
      4'd3:    v = pick(b, 8'h25, RF_CHANNEL);   // RF_CH
      4'd4:    v = pick(b, 8'h26, 8'h06);        // RF_SETUP
      4'd5:    v = pick(b, 8'h31, 8'h01);        // RX_PW_P0
      4'd6:    v = pick(b, 8'h27, 8'h70);        // STATUS
      4'd7:    v = pick(b, 8'h2A, addr_byte(b)); // RX_ADDR_P0
      4'd8:    v = 8'hE2;                        // FLUSH_RX
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  // Index of the last byte of init transaction t.
  function automatic logic [2:0] init_last(input logic [3:0] t);
    logic [2:0] v;
    v = 3'd1;
    case (t)
      4'd7:    v = 3'd5;
      4'd8:    v = 3'd0;
      default: v = 3'd1;
    endcase
    return v;
  endfunction

  // Next byte to shift and the last byte index of the current transaction.
  always_comb begin
    nxt_idx_s  = busy_q ? (bidx_q + 3'd1) : 3'd0;
    tx_byte_s  = 8'hFF;
    cur_last_s = 3'd0;
    case (state_q)
      ST_CFG: begin
        tx_byte_s  = pick(nxt_idx_s, 8'h20, 8'h0B);
        cur_last_s = 3'd1;
      end
      ST_INIT: begin
        tx_byte_s  = init_byte(tidx_q, nxt_idx_s);
        cur_last_s = init_last(tidx_q);
      end
      ST_NOP: begin
        tx_byte_s  = 8'hFF;
        cur_last_s = 3'd0;
      end
      ST_READ: begin
        tx_byte_s  = pick(nxt_idx_s, 8'h61, 8'hFF);
        cur_last_s = 3'd1;
      end
      ST_FLUSH: begin
        tx_byte_s  = 8'hE2;
        cur_last_s = 3'd0;
      end
      ST_CLR: begin
        tx_byte_s  = pick(nxt_idx_s, 8'h27, clr_val_q);
        cur_last_s = 3'd1;
      end
      default: begin
        tx_byte_s  = 8'hFF;
        cur_last_s = 3'd0;
      end
    endcase
  end

  // Three-flop synchronizer for the asynchronous IRQ line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_sync_q <= 3'b111;
    end else begin
      irq_sync_q <= {irq_sync_q[1:0], IRQ_n};
    end
  end

  // Main sequencer: init, IRQ service and SPI byte handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_CFG;
      busy_q         <= 1'b0;
      bidx_q         <= 3'd0;
      tidx_q         <= 4'd0;
      wait_q         <= 32'd0;
      clr_val_q      <= 8'h70;
      spi_start_q    <= 1'b0;
      spi_tx_q       <= 8'h00;
      spi_hold_csn_q <= 1'b0;
      ce_q           <= 1'b0;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      link_ready_q   <= 1'b0;
      pkt_cnt_q      <= 16'd0;
      rx_err_q       <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= ST_INIT;
            tidx_q  <= 4'd0;
            wait_q  <= 32'd0;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        ST_IDLE: begin
          if (irq_sync_q[2] == 1'b0) begin
            state_q <= ST_NOP;
          end
        end
        ST_CFG, ST_INIT, ST_NOP, ST_READ, ST_FLUSH, ST_CLR: begin
          if (!busy_q) begin
            // open a new transaction with its first byte
            spi_start_q    <= 1'b1;
            spi_tx_q       <= tx_byte_s;
            spi_hold_csn_q <= 1'b1;
            busy_q         <= 1'b1;
            bidx_q         <= 3'd0;
          end else if (spi_done) begin
            if (bidx_q != cur_last_s) begin
              spi_start_q <= 1'b1;
              spi_tx_q    <= tx_byte_s;
              bidx_q      <= nxt_idx_s;
            end else begin
              // last byte done: release CSN and pick the next step
              spi_hold_csn_q <= 1'b0;
              busy_q         <= 1'b0;
              bidx_q         <= 3'd0;
              case (state_q)
                ST_CFG: begin
                  state_q <= ST_WAIT;
                  wait_q  <= 32'd0;
                end
                ST_INIT: begin
                  if (tidx_q == 4'd8) begin
                    state_q      <= ST_IDLE;
                    ce_q         <= 1'b1;
                    link_ready_q <= 1'b1;
                  end else begin
                    tidx_q <= tidx_q + 4'd1;
                  end
                end
                ST_NOP: begin
                  if (spi_rx[6]) begin
                    if (spi_rx[3:1] == 3'b111) begin
                      rx_err_q <= 1'b1;
                      state_q  <= ST_FLUSH;
                    end else begin
                      state_q <= ST_READ;
                    end
                  end else begin
                    rx_err_q  <= 1'b1;
                    clr_val_q <= 8'h70;
                    state_q   <= ST_CLR;
                  end
                end
                ST_READ: begin
                  rx_data_q  <= spi_rx;
                  rx_valid_q <= 1'b1;
                  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                  clr_val_q  <= 8'h40;
                  state_q    <= ST_CLR;
                end
                ST_FLUSH: begin
                  clr_val_q <= 8'h40;
                  state_q   <= ST_CLR;
                end
                ST_CLR: begin
                  state_q <= ST_IDLE;
                end
                default: begin
                  state_q <= ST_CFG;
                end
              endcase
            end
          end
        end
        default: begin
          state_q <= ST_CFG;
        end
      endcase
    end
  end

`ifdef NRF24_RX_WATCHDOG_EN
  localparam logic [31:0] WDOG_CYC = 32'(WDOG_MS * (SYS_CLK_HZ / 1000));

  logic [31:0] wdog_q;
  logic        link_lost_q;

  // Link watchdog: counts idle/service time since the last delivered payload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q      <= 32'd0;
      link_lost_q <= 1'b0;
    end else if (rx_valid_q) begin
      wdog_q      <= 32'd0;
      link_lost_q <= 1'b0;
    end else if (link_ready_q) begin
      if (wdog_q >= WDOG_CYC) begin
        link_lost_q <= 1'b1;
      end else begin
        wdog_q <= wdog_q + 32'd1;
      end
    end
  end

  assign link_lost = link_lost_q;
`else
  assign link_lost = 1'b0;
`endif

  assign spi_start    = spi_start_q;
  assign spi_tx       = spi_tx_q;
  assign spi_hold_csn = spi_hold_csn_q;
  assign CE           = ce_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign link_ready   = link_ready_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign rx_err       = rx_err_q;

endmodule

// File: tb/tb_nrf24_controller_rx.sv
// tb_nrf24_controller_rx: scoreboard bench with an nRF24L01 + SPI master model.
module tb_nrf24_controller_rx;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned WAIT_CYC = 2 * (CLK_HZ / 1000);

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_done = 1'b0;
  logic        spi_hold_csn;
  logic        CE;
  logic        irq_n = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        link_ready;
  logic [15:0] pkt_cnt;
  logic        rx_err;
  logic        link_lost;

  nrf24_controller_rx #(
    .SYS_CLK_HZ (CLK_HZ),
    .RF_CHANNEL (8'h4c),
    .NRF_RX_ADDR(40'hE7E7E7E7E7),
    .WDOG_MS    (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi_start   (spi_start),
    .spi_tx      (spi_tx),
    .spi_rx      (spi_rx),
    .spi_done    (spi_done),
    .spi_hold_csn(spi_hold_csn),
    .CE          (CE),
    .IRQ_n       (irq_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .link_ready  (link_ready),
    .pkt_cnt     (pkt_cnt),
    .rx_err      (rx_err),
    .link_lost   (link_lost)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes[$];    // expected SPI byte stream
  logic [7:0] exp_payload[$];  // expected rx_data deliveries
  logic [7:0] ev_status[$];    // radio model: pending packets
  logic [7:0] ev_payload[$];
  int exp_pkt = 0;
  int exp_errs = 0;
  int seen_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SPI master + radio model ----------------
  int         spi_cnt = 0;
  logic [7:0] spi_resp = 8'h00;
  logic [7:0] prev_b = 8'h00;

  always @(negedge clk) begin
    if (!rstn) begin
      spi_cnt  = 0;
      spi_done = 1'b0;
      prev_b   = 8'h00;
    end else begin
      spi_done = 1'b0;
      if (spi_start) begin
        chk("one_outstanding", spi_cnt, 0);
        chk("hold_csn", spi_hold_csn, 1);
        spi_cnt = 8;
        spi_resp = 8'h0E;
        if (spi_tx == 8'hFF) begin
          if (prev_b == 8'h61)
            spi_resp = (ev_payload.size() > 0) ? ev_payload[0] : 8'h00;
          else
            spi_resp = (ev_status.size() > 0) ? ev_status[0] : 8'h0E;
        end
        if (link_ready && spi_tx == 8'h27) begin
          if (ev_status.size() > 0) begin
            void'(ev_status.pop_front());
            void'(ev_payload.pop_front());
          end
          if (ev_status.size() == 0) irq_n = 1'b1;
        end
        prev_b = spi_tx;
      end else if (spi_cnt != 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          spi_done = 1'b1;
          spi_rx   = spi_resp;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int unsigned t_0b = 0;
  logic [7:0]  mon_e;

  always @(negedge clk) begin
    if (rstn) begin
      if (spi_start) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_byte: got %0h expected no byte", spi_tx);
        end else begin
          mon_e = exp_bytes.pop_front();
          chk("spi_byte", spi_tx, mon_e);
        end
        if (!link_ready) begin
          chk("ce_init", CE, 0);
          if (spi_tx == 8'h0B) t_0b = cyc;
          if (spi_tx == 8'h21) chk("init_gap", (cyc - t_0b) >= (WAIT_CYC + 8), 1);
        end else begin
          chk("ce_run", CE, 1);
        end
      end
      if (rx_valid) begin
        if (exp_payload.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid: got %0h expected no delivery", rx_data);
        end else begin
          mon_e = exp_payload.pop_front();
          chk("rx_data", rx_data, mon_e);
        end
        exp_pkt++;
        chk("pkt_cnt", pkt_cnt, exp_pkt);
      end
      if (rx_err) seen_errs++;
    end
  end

  // ---------------- reference: expected byte streams ----------------
  task automatic push_init();
    logic [39:0] addr;
    addr = 40'hE7E7E7E7E7;
    exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h0B);
    exp_bytes.push_back(8'h21); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h23); exp_bytes.push_back(8'h03);
    exp_bytes.push_back(8'h25); exp_bytes.push_back(8'h4C);
    exp_bytes.push_back(8'h26); exp_bytes.push_back(8'h06);
    exp_bytes.push_back(8'h31); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h27); exp_bytes.push_back(8'h70);
    exp_bytes.push_back(8'h2A);
    for (int i = 0; i < 5; i++) exp_bytes.push_back(addr[8*i +: 8]);
    exp_bytes.push_back(8'hE2);
  endtask

  task automatic add_event(input logic [7:0] st, input logic [7:0] pl);
    ev_status.push_back(st);
    ev_payload.push_back(pl);
    exp_bytes.push_back(8'hFF);
    if (st[6] && st[3:1] != 3'b111) begin
      exp_bytes.push_back(8'h61); exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h27); exp_bytes.push_back(8'h40);
      exp_payload.push_back(pl);
    end else if (st[6]) begin
      exp_errs++;
      exp_bytes.push_back(8'hE2);
      exp_bytes.push_back(8'h27); exp_bytes.push_back(8'h40);
    end else begin
      exp_errs++;
      exp_bytes.push_back(8'h27); exp_bytes.push_back(8'h70);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_spi_start"}, spi_start, 0);
    chk({tag, "_spi_tx"}, spi_tx, 0);
    chk({tag, "_hold_csn"}, spi_hold_csn, 0);
    chk({tag, "_ce"}, CE, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_link_ready"}, link_ready, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_rx_err"}, rx_err, 0);
    chk({tag, "_link_lost"}, link_lost, 0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!link_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", link_ready, 1);
    chk("ce_after_init", CE, 1);
    chk("init_bytes_left", exp_bytes.size(), 0);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || irq_n == 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("service_done", (exp_bytes.size() == 0) && (irq_n == 1'b1), 1);
    repeat (30) @(negedge clk);
    chk("payload_left", exp_payload.size(), 0);
    chk("rx_err_count", seen_errs, exp_errs);
  endtask

  task automatic one_packet(input logic [7:0] st, input logic [7:0] pl);
    add_event(st, pl);
    irq_n = 1'b0;
    wait_quiet();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] st;
    int n;
    repeat (3) @(negedge clk);
    check_reset("por");
    push_init();
    rstn = 1'b1;
    wait_ready();

    // good packet
    one_packet(8'h40, 8'h5A);
    chk("rx_data_5a", rx_data, 8'h5A);
    chk("pkt_cnt_1", pkt_cnt, 1);
    // spurious IRQ
    one_packet(8'h0E, 8'h00);
    chk("pkt_cnt_spur", pkt_cnt, 1);
    // two packets with IRQ held low
    add_event(8'h40, 8'h11);
    add_event(8'h40, 8'h22);
    irq_n = 1'b0;
    wait_quiet();
    chk("pkt_cnt_b2b", pkt_cnt, 3);
    chk("rx_data_b2b", rx_data, 8'h22);
    // invalid pipe
    one_packet(8'h4E, 8'h99);

    // randomized packets
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    begin
                   st = {1'b0, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), 1'b0};
                 end
        2:       st = {1'b0, 1'b1, 2'($urandom_range(0, 3)), 3'b111, 1'b0};
        default: st = {1'b0, 1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0};
      endcase
      one_packet(st, 8'($urandom_range(0, 255)));
    end

    // link watchdog
    repeat (1100) @(negedge clk);
`ifdef NRF24_RX_WATCHDOG_EN
    chk("link_lost_set", link_lost, 1);
`else
    chk("link_lost_off", link_lost, 0);
`endif
    one_packet(8'h40, 8'h3C);
    chk("link_lost_clr", link_lost, 0);

    // reset in the middle of a payload read
    add_event(8'h40, 8'hA5);
    irq_n = 1'b0;
    n = 0;
    while (!(spi_start && spi_tx == 8'h61) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("saw_payload_cmd", n < 200, 1);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    irq_n = 1'b1;
    exp_bytes.delete();
    exp_payload.delete();
    ev_status.delete();
    ev_payload.delete();
    exp_pkt = 0;
    exp_errs = 0;
    seen_errs = 0;
    @(negedge clk);
    check_reset("midread");
    push_init();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_ready();
    one_packet(8'h42, 8'hC3);
    chk("pkt_cnt_after_rst", pkt_cnt, 1);
    chk("rx_data_after_rst", rx_data, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
